hi_trace_ctrl: RTL



---
 rtl/hi_trace_ctrl_if.sv | 56 +++++
 rtl/hi_trace_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hi_trace_ctrl_if.sv
// -----------------------------------------------------------------------------
// hi_trace_ctrl_if
//
// Purpose:
//   Bundles the control and status signals of the HF trace capture sequencer.
//   The sequencer (hi_trace_ctrl) connects through the master modport. The
//   firmware/readout side and the trace buffer connect through the slave
//   modport.
//
// Signals:
//   adc_d         8       ADC sample, unsigned
//   arm           1       capture request level; a rising edge starts a capture
//   abort         1       synchronous abort, level
//   threshold     8       trigger level, unsigned
//   pre_count     ADDR_W  minimum samples written before a trigger is accepted
//   post_count    ADDR_W  samples written after the trigger sample
//   trace_enable  1       write enable to the trace buffer
//   sample_strobe 1       one-cycle pulse per sample period
//   wr_addr       ADDR_W  current buffer write address
//   trig_addr     ADDR_W  address of the trigger sample
//   start_addr    ADDR_W  oldest valid sample address (valid when done=1)
//   state         2       00 IDLE, 01 PRE, 10 ARMED, 11 POST
//   done          1       capture complete, buffer frozen
// -----------------------------------------------------------------------------
interface hi_trace_ctrl_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]        adc_d;
  logic              arm;
  logic              abort;
  logic [7:0]        threshold;
  logic [ADDR_W-1:0] pre_count;
  logic [ADDR_W-1:0] post_count;

  logic              trace_enable;
  logic              sample_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;
  logic [1:0]        state;
  logic              done;

  // Sequencer side
  modport master (
    input  adc_d, arm, abort, threshold, pre_count, post_count,
    output trace_enable, sample_strobe, wr_addr, trig_addr, start_addr,
           state, done
  );

  // Firmware / trace buffer side
  modport slave (
    output adc_d, arm, abort, threshold, pre_count, post_count,
    input  trace_enable, sample_strobe, wr_addr, trig_addr, start_addr,
           state, done
  );
endinterface

// File: rtl/hi_trace_ctrl.sv
// -----------------------------------------------------------------------------
// hi_trace_ctrl
//
// Purpose:
//   Capture sequencer for the HF trace ring buffer (DEPTH x u8, one sample per
//   SAMPLE_DIV ck_1356megb cycles). It generates the sample strobe, drives the
//   buffer write enable and write address, and runs the capture sequence:
//   arm -> minimum pre-trigger fill -> ADC amplitude trigger -> post-trigger
//   sample count -> freeze. On completion it reports the trigger address and
//   the oldest valid sample address so readout starts at the right sample.
//
// Ports:
//   ck_1356megb  in   sole clock; all state changes on the falling edge
//   rst_n        in   synchronous reset, active-low
//   bus          --   hi_trace_ctrl_if.master (see the interface for signals)
//
// Build option:
//   TRACE_CTRL_EDGE_TRIG_EN
//     defined   : trigger needs a rising crossing (previous written sample
//                 below threshold, current sample at/above threshold). The
//                 previous-sample register is loaded with 8'hFF on arm so the
//                 first sample of a capture can never trigger.
//     undefined : level trigger (adc_d >= threshold).
// -----------------------------------------------------------------------------
module hi_trace_ctrl #(
  parameter int DEPTH      = 3072,
  parameter int ADDR_W     = 12,
  parameter int SAMPLE_DIV = 8
) (
  input logic            ck_1356megb,
  input logic            rst_n,
  hi_trace_ctrl_if.master bus
);

  localparam int DIV_W  = $clog2(SAMPLE_DIV);
  // One extra bit so the fill counter can hold DEPTH itself.
  localparam int FILL_W = ADDR_W + 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRE   = 2'b01,
    ST_ARMED = 2'b10,
    ST_POST  = 2'b11
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t            state_reg;
  logic [DIV_W-1:0]  div_reg;
  logic              arm_q_reg;
  logic              trace_enable_reg;
  logic              done_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [ADDR_W-1:0] arm_addr_reg;
  logic [ADDR_W-1:0] trig_addr_reg;
  logic [ADDR_W-1:0] start_addr_reg;
  logic [ADDR_W-1:0] post_cnt_reg;
  logic [FILL_W-1:0] fill_reg;
`ifdef TRACE_CTRL_EDGE_TRIG_EN
  logic [7:0]        prev_sample_reg;
`endif

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic              strobe;
  logic              write_now;
  logic              arm_rise;
  logic              trig_hit;
  logic              pre_met;
  logic [ADDR_W-1:0] addr_next;
  logic [FILL_W-1:0] fill_next;
  logic [ADDR_W-1:0] pre_target;
  logic [ADDR_W-1:0] post_load;
  logic [ADDR_W-1:0] start_on_done;

  always_comb begin
    strobe    = (div_reg == DIV_LAST);
    // The buffer writes at the current (pre-increment) address on this strobe.
    write_now = strobe & trace_enable_reg;
    arm_rise  = bus.arm & ~arm_q_reg;

    addr_next = (wr_addr_reg == ADDR_LAST) ? '0 : wr_addr_reg + 1'b1;
    fill_next = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + 1'b1;

    // A pre-fill of DEPTH samples could never be reached together with a
    // trigger sample, so the requirement is capped at DEPTH-1.
    pre_target = (bus.pre_count > ADDR_LAST) ? ADDR_LAST : bus.pre_count;
    pre_met    = (fill_reg >= {1'b0, pre_target});

    // Capping the post count keeps the trigger sample from being overwritten.
    post_load  = (bus.post_count > ADDR_LAST) ? ADDR_LAST : bus.post_count;

`ifdef TRACE_CTRL_EDGE_TRIG_EN
    trig_hit = (prev_sample_reg < bus.threshold) && (bus.adc_d >= bus.threshold);
`else
    trig_hit = (bus.adc_d >= bus.threshold);
`endif

    // Completion always coincides with the final write, so the oldest valid
    // sample is evaluated against the post-write address and fill level: once
    // the ring has wrapped, the next slot to be written is the oldest sample.
    start_on_done = (fill_next == FILL_FULL) ? addr_next : arm_addr_reg;
  end

  // ---------------------------------------------------------------------------
  // Divider, addressing and capture state machine
  // ---------------------------------------------------------------------------
  always_ff @(negedge ck_1356megb) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      div_reg          <= '0;
      arm_q_reg        <= 1'b0;
      trace_enable_reg <= 1'b0;
      done_reg         <= 1'b0;
      wr_addr_reg      <= '0;
      arm_addr_reg     <= '0;
      trig_addr_reg    <= '0;
      start_addr_reg   <= '0;
      post_cnt_reg     <= '0;
      fill_reg         <= '0;
`ifdef TRACE_CTRL_EDGE_TRIG_EN
      prev_sample_reg  <= '0;
`endif
    end else begin
      // Free-running sample divider, independent of capture state.
      div_reg   <= strobe ? '0 : div_reg + 1'b1;
      arm_q_reg <= bus.arm;

      if (bus.abort) begin
        // Abort wins over trigger and arm; addresses are left untouched.
        state_reg        <= ST_IDLE;
        trace_enable_reg <= 1'b0;
        done_reg         <= 1'b0;
      end else begin
        if (write_now) begin
          wr_addr_reg     <= addr_next;
          fill_reg        <= fill_next;
`ifdef TRACE_CTRL_EDGE_TRIG_EN
          prev_sample_reg <= bus.adc_d;
`endif
        end

        unique case (state_reg)
          ST_IDLE: begin
            // trace_enable is low here, so no write competes with this load.
            if (arm_rise) begin
              state_reg        <= ST_PRE;
              trace_enable_reg <= 1'b1;
              done_reg         <= 1'b0;
              fill_reg         <= '0;
              arm_addr_reg     <= wr_addr_reg;
`ifdef TRACE_CTRL_EDGE_TRIG_EN
              prev_sample_reg  <= 8'hFF;
`endif
            end
          end

          ST_PRE: begin
            if (pre_met) begin
              state_reg <= ST_ARMED;
            end
          end

          ST_ARMED: begin
            if (write_now && trig_hit) begin
              trig_addr_reg <= wr_addr_reg;
              if (post_load == '0) begin
                // Trigger sample is the last one written.
                state_reg        <= ST_IDLE;
                trace_enable_reg <= 1'b0;
                done_reg         <= 1'b1;
                start_addr_reg   <= start_on_done;
              end else begin
                state_reg    <= ST_POST;
                post_cnt_reg <= post_load;
              end
            end
          end

          ST_POST: begin
            // post_cnt_reg counts the writes still owed, including this one.
            if (write_now) begin
              if (post_cnt_reg == ADDR_W'(1)) begin
                state_reg        <= ST_IDLE;
                trace_enable_reg <= 1'b0;
                done_reg         <= 1'b1;
                start_addr_reg   <= start_on_done;
                post_cnt_reg     <= '0;
              end else begin
                post_cnt_reg <= post_cnt_reg - 1'b1;
              end
            end
          end

          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.sample_strobe = strobe;
  assign bus.trace_enable  = trace_enable_reg;
  assign bus.wr_addr       = wr_addr_reg;
  assign bus.trig_addr     = trig_addr_reg;
  assign bus.start_addr    = start_addr_reg;
  assign bus.state         = state_reg;
  assign bus.done          = done_reg;

endmodule
